pc_sequencer: RTL and testbench



---
 rtl/proc_pkg.sv | 22 ++
 rtl/pc_sequencer_if.sv | 42 ++++
 rtl/pc_sequencer_ret_stack.sv | 75 +++++++
 rtl/pc_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_pc_sequencer.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/proc_pkg.sv
// ---------------------------------------------------------------------------
// proc_pkg
// Shared definitions for the program-counter stage:
//   PC_WIDTH      default PC / adder datapath width
//   PC_RESET_VAL  default PC value after reset
//   INC_ONE       sequential-fetch increment fed to the adder
//   pc_state_e    sequencer FSM states
// ---------------------------------------------------------------------------
package proc_pkg;

    localparam int PC_WIDTH     = 8;
    localparam int PC_RESET_VAL = 0;
    localparam int INC_ONE      = 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_UPDATE = 2'd2,
        ST_HALTED = 2'd3
    } pc_state_e;

endpackage : proc_pkg

// File: rtl/pc_sequencer_if.sv
// ---------------------------------------------------------------------------
// pc_sequencer_if
// Bus between the PC sequencer and its neighbours: the instruction-memory
// fetch handshake plus the operand/result wires of the external adder.
//   imem_req   fetch request, pc_out valid while high
//   imem_ack   memory accepted the fetch of pc_out
//   pc_out     current PC
//   adder_in1  adder operand 1 (always the PC)
//   adder_in2  adder operand 2 (+1 or branch offset)
//   adder_sum  adder result
// Modports:
//   master  sequencer side
//   slave   memory/adder side
// ---------------------------------------------------------------------------
interface pc_sequencer_if #(
    parameter int WIDTH = 8
);
    logic             imem_req;
    logic             imem_ack;
    logic [WIDTH-1:0] pc_out;
    logic [WIDTH-1:0] adder_in1;
    logic [WIDTH-1:0] adder_in2;
    logic [WIDTH-1:0] adder_sum;

    modport master (
        output imem_req,
        output pc_out,
        output adder_in1,
        output adder_in2,
        input  imem_ack,
        input  adder_sum
    );

    modport slave (
        input  imem_req,
        input  pc_out,
        input  adder_in1,
        input  adder_in2,
        output imem_ack,
        output adder_sum
    );
endinterface : pc_sequencer_if

// File: rtl/pc_sequencer_ret_stack.sv
// ---------------------------------------------------------------------------
// ret_stack
// Small LIFO of return addresses (DEPTH x WIDTH). Only instantiated when the
// sequencer is built with PC_CALL_STACK_EN.
// Ports:
//   clk, rst    clock, asynchronous active-high reset (clears the stack)
//   push        write push_data on top (ignored when full)
//   push_data   value to push
//   pop         remove the top entry (ignored when empty)
//   top         current top entry, combinational
//   full,empty  occupancy flags
// ---------------------------------------------------------------------------
module ret_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] top,
    output logic             full,
    output logic             empty
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [CW-1:0]    count_reg;
    logic [WIDTH-1:0] entry [DEPTH];

    logic do_push;
    logic do_pop;

    assign full    = (count_reg == CW'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Each slot is its own register; slot gi is written when it is the next
    // free position.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic [WIDTH-1:0] data_reg;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                data_reg <= '0;
            end else if (do_push && (count_reg == CW'(gi))) begin
                data_reg <= push_data;
            end
        end

        assign entry[gi] = data_reg;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (do_push && !do_pop) begin
            count_reg <= count_reg + CW'(1);
        end else if (do_pop && !do_push) begin
            count_reg <= count_reg - CW'(1);
        end
    end

    // Top of stack is the slot just below the fill count.
    always_comb begin
        top = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (count_reg == CW'(i + 1)) begin
                top = entry[i];
            end
        end
    end

endmodule : ret_stack

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
// Program-counter stage. Holds the PC, feeds the external adder
// (in1 = PC, in2 = +1 or branch offset), loads the adder result back into the
// PC, and sequences instruction fetches with a req/ack handshake.
// FSM: IDLE -> FETCH (req high until ack) -> UPDATE (one cycle) -> FETCH/IDLE,
// or UPDATE -> HALTED on halt (left only through reset).
// UPDATE priority: halt > jump > branch > increment.
//
// Optional build macro PC_CALL_STACK_EN adds call/ret inputs, a stack_err
// output and a return stack. Priority then is
// halt > ret > call > jump > branch > increment.
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   en               start/continue sequencing
//   jump, jump_addr  absolute jump (sampled in UPDATE)
//   branch, branch_off  PC-relative branch (sampled in UPDATE)
//   halt             stop after the current fetch (sampled in UPDATE)
//   call, ret        subroutine call/return (PC_CALL_STACK_EN only)
//   stack_err        one-cycle pulse on call-when-full / ret-when-empty
//                    (PC_CALL_STACK_EN only)
//   wrap             one-cycle pulse when an increment rolls over to 0
//   halted           high in HALTED
//   bus              fetch handshake, pc_out and adder operands (master)
// ---------------------------------------------------------------------------
module pc_sequencer
    import proc_pkg::*;
#(
    parameter int               WIDTH       = PC_WIDTH,
`ifdef PC_CALL_STACK_EN
    parameter int               STACK_DEPTH = 4,
`endif
    parameter logic [WIDTH-1:0] RESET_PC    = WIDTH'(PC_RESET_VAL)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_addr,
    input  logic             branch,
    input  logic [WIDTH-1:0] branch_off,
    input  logic             halt,
`ifdef PC_CALL_STACK_EN
    input  logic             call,
    input  logic             ret,
    output logic             stack_err,
`endif
    output logic             wrap,
    output logic             halted,
    pc_sequencer_if.master   bus
);

    pc_state_e        state_reg;
    logic [WIDTH-1:0] pc_reg;
    logic             req_reg;
    logic             wrap_reg;
    logic             halted_reg;

    logic [WIDTH-1:0] pc_next;
    logic [WIDTH-1:0] in2_next;
    logic             inc_sel;      // UPDATE is taking the plain +1 path
    logic             update_go;    // UPDATE cycle that changes the PC

`ifdef PC_CALL_STACK_EN
    logic             err_reg;
    logic             err_next;
    logic             stack_push;
    logic             stack_pop;
    logic             stack_full;
    logic             stack_empty;
    logic [WIDTH-1:0] stack_top;

    // Return address is PC+1, which is what the adder produces while a call
    // is being serviced (in2 stays at +1 on that path).
    ret_stack #(
        .WIDTH (WIDTH),
        .DEPTH (STACK_DEPTH)
    ) u_ret_stack (
        .clk       (clk),
        .rst       (rst),
        .push      (stack_push),
        .push_data (bus.adder_sum),
        .pop       (stack_pop),
        .top       (stack_top),
        .full      (stack_full),
        .empty     (stack_empty)
    );

    assign stack_err = err_reg;
`endif

    assign update_go = (state_reg == ST_UPDATE) && !halt;

    // Next-PC selection and adder operand 2. The adder result is the default
    // next PC; only jumps/returns bypass it.
    always_comb begin
        pc_next  = bus.adder_sum;
        in2_next = WIDTH'(INC_ONE);
        inc_sel  = 1'b0;
`ifdef PC_CALL_STACK_EN
        err_next   = 1'b0;
        stack_push = 1'b0;
        stack_pop  = 1'b0;
`endif
        if (update_go) begin
`ifdef PC_CALL_STACK_EN
            if (ret && !stack_empty) begin
                pc_next   = stack_top;
                stack_pop = 1'b1;
            end else if (ret) begin
                // Return with nothing to return to: fall through as +1.
                inc_sel  = 1'b1;
                err_next = 1'b1;
            end else if (call) begin
                // A full stack drops the return address but still jumps.
                pc_next    = jump_addr;
                stack_push = !stack_full;
                err_next   = stack_full;
            end else
`endif
            if (jump) begin
                pc_next = jump_addr;
            end else if (branch) begin
                in2_next = branch_off;
            end else begin
                inc_sel = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            pc_reg     <= RESET_PC;
            req_reg    <= 1'b0;
            wrap_reg   <= 1'b0;
            halted_reg <= 1'b0;
`ifdef PC_CALL_STACK_EN
            err_reg    <= 1'b0;
`endif
        end else begin
            wrap_reg <= 1'b0;
`ifdef PC_CALL_STACK_EN
            err_reg  <= 1'b0;
`endif
            case (state_reg)
                ST_IDLE: begin
                    if (en) begin
                        state_reg <= ST_FETCH;
                        req_reg   <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    // Request and PC stay put until memory accepts.
                    if (bus.imem_ack) begin
                        state_reg <= ST_UPDATE;
                        req_reg   <= 1'b0;
                    end
                end
                ST_UPDATE: begin
                    if (halt) begin
                        state_reg  <= ST_HALTED;
                        halted_reg <= 1'b1;
                    end else begin
                        pc_reg   <= pc_next;
                        // Only a sequential increment reports rollover;
                        // branches wrap silently.
                        wrap_reg <= inc_sel && (pc_reg == '1);
`ifdef PC_CALL_STACK_EN
                        err_reg  <= err_next;
`endif
                        if (en) begin
                            state_reg <= ST_FETCH;
                            req_reg   <= 1'b1;
                        end else begin
                            state_reg <= ST_IDLE;
                        end
                    end
                end
                ST_HALTED: begin
                    state_reg <= ST_HALTED;
                end
                default: begin
                    state_reg <= ST_IDLE;
                    req_reg   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.imem_req  = req_reg;
    assign bus.pc_out    = pc_reg;
    assign bus.adder_in1 = pc_reg;
    assign bus.adder_in2 = in2_next;
    assign wrap          = wrap_reg;
    assign halted        = halted_reg;

endmodule : pc_sequencer

// File: tb/tb_pc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pc_sequencer
// Directed bench for pc_sequencer. The stimulus side pushes the expected next
// fetch into a queue; the negedge monitor acknowledges requests (after a
// programmable delay) and checks every accepted fetch against the queue.
// The external adder is modelled here as a plain 8-bit add.
// ---------------------------------------------------------------------------
module tb_pc_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       jump;
    logic [7:0] jump_addr;
    logic       branch;
    logic [7:0] branch_off;
    logic       halt;
    logic       call;
    logic       ret;
    logic       wrap;
    logic       halted;
`ifdef PC_CALL_STACK_EN
    logic       stack_err;
`endif

    pc_sequencer_if #(.WIDTH(8)) bus ();

    assign bus.adder_sum = bus.adder_in1 + bus.adder_in2;

    pc_sequencer #(
        .WIDTH    (8),
        .RESET_PC (8'h00)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .jump       (jump),
        .jump_addr  (jump_addr),
        .branch     (branch),
        .branch_off (branch_off),
        .halt       (halt),
`ifdef PC_CALL_STACK_EN
        .call       (call),
        .ret        (ret),
        .stack_err  (stack_err),
`endif
        .wrap       (wrap),
        .halted     (halted),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] pc;
        int         req_cycles;
        int         gap;          // 0: no spacing check for this fetch
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         total = 0;
    int         bad = 0;
    int         accept_count = 0;
    int         consumed = 0;
    int         ack_delay = 0;
    int         wait_cnt = 0;
    int         req_cnt = 0;
    int         ncnt = 0;
    int         last_accept = 0;
    logic [7:0] pc_first;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory responder + scoreboard monitor.
    always @(negedge clk) begin
        ncnt++;
        if (rst || bus.imem_req !== 1'b1) begin
            bus.imem_ack = 1'b0;
            wait_cnt     = 0;
            req_cnt      = 0;
        end else begin
            if (req_cnt == 0) pc_first = bus.pc_out;
            req_cnt++;
            if (bus.imem_ack !== 1'b1) begin
                if (wait_cnt >= ack_delay) bus.imem_ack = 1'b1;
                else wait_cnt++;
            end
            if (bus.imem_ack === 1'b1) begin
                accept_count++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_fetch: got pc %0h expected no request", bus.pc_out);
                end else begin
                    mon_e = exp_q.pop_front();
                    $display("fetch pc=%02h req_cycles=%0d gap=%0d", bus.pc_out, req_cnt, ncnt - last_accept);
                    check("fetch_pc", bus.pc_out, mon_e.pc);
                    check("fetch_in1", bus.adder_in1, mon_e.pc);
                    check("fetch_in2", bus.adder_in2, 8'h01);
                    check("req_hold", req_cnt, mon_e.req_cycles);
                    check("pc_stable", pc_first, mon_e.pc);
                    if (mon_e.gap != 0) check("fetch_gap", ncnt - last_accept, mon_e.gap);
                end
                last_accept = ncnt;
            end
        end
    end

    task automatic wait_accept(output logic ok);
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (accept_count > consumed) break;
        end
        ok = (accept_count > consumed);
        if (ok) begin
            consumed = accept_count;
        end else begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got %0d accepts expected %0d", accept_count, consumed + 1);
        end
    endtask

    // Completes the current fetch, applies controls in its UPDATE cycle and
    // expects the following fetch at next_pc (or PC held at next_pc on halt).
    task automatic step(input string name, input logic j, input logic [7:0] ja,
                        input logic b, input logic [7:0] bo, input logic h,
                        input logic [7:0] next_pc, input int next_delay,
                        input logic exp_wrap, input logic c = 1'b0, input logic r = 1'b0);
        logic       ok;
        logic [7:0] exp_in2;
        wait_accept(ok);
        if (ok) begin
            check({name, ".wrap_low"}, wrap, 1'b0);
            jump = j; jump_addr = ja; branch = b; branch_off = bo;
            halt = h; call = c; ret = r;
            ack_delay = next_delay;
            if (!h) exp_q.push_back('{next_pc, next_delay + 1, next_delay + 2});
            exp_in2 = (b && !j && !h && !c && !r) ? bo : 8'h01;
            @(negedge clk);
            check({name, ".in2"}, bus.adder_in2, exp_in2);
            @(posedge clk);
            #1;
            check({name, ".pc"}, bus.pc_out, next_pc);
            check({name, ".wrap"}, wrap, exp_wrap);
            check({name, ".halted"}, halted, h);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected test end");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; en = 1'b0; jump = 1'b0; jump_addr = 8'h00; branch = 1'b0;
        branch_off = 8'h00; halt = 1'b0; call = 1'b0; ret = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_pc", bus.pc_out, 8'h00);
        check("rst_req", bus.imem_req, 1'b0);
        check("rst_wrap", wrap, 1'b0);
        check("rst_halted", halted, 1'b0);
        check("rst_in1", bus.adder_in1, 8'h00);
        check("rst_in2", bus.adder_in2, 8'h01);

        exp_q.push_back('{8'h00, 1, 0});
        ack_delay = 0;
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b1;

        //   name   j  ja     b  bo     h  next   dly wrap
        step("inc0", 0, 8'h00, 0, 8'h00, 0, 8'h01, 0, 0);
        step("inc1", 0, 8'h00, 0, 8'h00, 0, 8'h02, 0, 0);
        step("inc2", 0, 8'h00, 0, 8'h00, 0, 8'h03, 0, 0);
        step("jmp10", 1, 8'h10, 0, 8'h00, 0, 8'h10, 0, 0);
        step("brm4", 0, 8'h00, 1, 8'hFC, 0, 8'h0C, 0, 0);
        step("jmp10b", 1, 8'h10, 0, 8'h00, 0, 8'h10, 0, 0);
        step("jmpwin", 1, 8'h80, 1, 8'hFC, 0, 8'h80, 0, 0);
        step("brwrap", 0, 8'h00, 1, 8'h90, 0, 8'h10, 0, 0);
        step("jmpff", 1, 8'hFF, 0, 8'h00, 0, 8'hFF, 0, 0);
        step("incwrap", 0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 1);
        step("slowack", 0, 8'h00, 0, 8'h00, 0, 8'h01, 3, 0);
`ifdef PC_CALL_STACK_EN
        step("jmp20", 1, 8'h20, 0, 8'h00, 0, 8'h20, 0, 0);
        step("call40", 0, 8'h40, 0, 8'h00, 0, 8'h40, 0, 0, 1'b1, 1'b0);
        check("call.stack_err", stack_err, 1'b0);
        step("ret21", 0, 8'h00, 0, 8'h00, 0, 8'h21, 0, 0, 1'b0, 1'b1);
        check("ret.stack_err", stack_err, 1'b0);
        step("retempty", 0, 8'h00, 0, 8'h00, 0, 8'h22, 0, 0, 1'b0, 1'b1);
        check("retempty.stack_err", stack_err, 1'b1);
        step("jmp05", 1, 8'h05, 0, 8'h00, 0, 8'h05, 0, 0);
        check("jmp05.stack_err", stack_err, 1'b0);
`else
        step("jmp05", 1, 8'h05, 0, 8'h00, 0, 8'h05, 0, 0);
`endif
        step("halt", 0, 8'h00, 0, 8'h00, 1, 8'h05, 0, 0);

        repeat (10) @(posedge clk);
        #1;
        check("halt_pc", bus.pc_out, 8'h05);
        check("halt_req", bus.imem_req, 1'b0);
        check("halt_hold", halted, 1'b1);
        check("halt_nofetch", accept_count, consumed);

        // Reset is the only exit from HALTED.
        halt = 1'b0; jump = 1'b0; branch = 1'b0;
        rst = 1'b1;
        #1;
        check("rst2_halted", halted, 1'b0);
        check("rst2_pc", bus.pc_out, 8'h00);
        exp_q.push_back('{8'h00, 1, 0});
        ack_delay = 0;
        @(negedge clk);
        rst = 1'b0;
        step("r_inc0", 0, 8'h00, 0, 8'h00, 0, 8'h01, 0, 0);
        step("r_inc1", 0, 8'h00, 0, 8'h00, 0, 8'h02, 10, 0);

        // Assert reset mid-cycle while the fetch of 02 is waiting for ack.
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (bus.imem_req === 1'b1) break;
        end
        check("mid_fetch_req", bus.imem_req, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("async_pc", bus.pc_out, 8'h00);
        check("async_req", bus.imem_req, 1'b0);
        exp_q.delete();
        en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("idle_req", bus.imem_req, 1'b0);
        check("idle_pc", bus.pc_out, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_pc_sequencer
